// File: rtl/dec_timer_16.sv
// Loadable countdown timer with one-shot / periodic auto-reload and pause/resume.
// Counts a loaded value down to zero and pulses expire for one cycle on reaching it.
module dec_timer_16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expire
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             expire_q, expire_d;
    logic [WIDTH-1:0] count_dec;
    logic             last_step;
    logic             run_step;

    // Decrement as an add of all-ones; RUN never steps from zero, so no wrap occurs.
    assign count_dec = count_q + '1;
    assign last_step = (count_q == WIDTH'(1));
    assign run_step  = (state_q == S_RUN) && !stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: if (start && (count_q != '0)) state_d = S_RUN;
                S_RUN: begin
                    if (stop) begin
                        state_d = S_IDLE;
                    end else if (last_step && !periodic) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: if (start) state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        expire_d = 1'b0;
        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
        end else if (run_step) begin
            if (last_step) begin
                expire_d = 1'b1;
                count_d  = periodic ? reload_q : '0;
            end else begin
                count_d = count_dec;
            end
        end else if ((state_q == S_DONE) && start) begin
            count_d = reload_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            reload_q <= '0;
            expire_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
            expire_q <= expire_d;
        end
    end

    always_comb begin
        busy   = (state_q == S_RUN);
        count  = count_q;
        expire = expire_q;
    end

endmodule

// File: doc/dec_timer_16.md
Name: dec_timer_16

Overview:
- Loadable 16-bit countdown timer: the decrementing counterpart of the team's combinational incrementer, wrapped in a small control FSM.
- Counts a loaded value down to zero, one step per clock, and pulses `expire` on reaching zero.
- Supports one-shot and periodic (auto-reload) modes, plus pause/resume.
- Used as the delay/tick source for CPU-side peripherals.

Parameters:
- WIDTH, 16, counter and load-value width in bits. All values below assume 16.

Ports:
- clk       input   1      rising-edge clock
- rst_n     input   1      asynchronous active-low reset
- load      input   1      load `load_val` into count and reload registers
- load_val  input   16     value to load
- start     input   1      begin or resume counting
- stop      input   1      pause counting (hold count)
- periodic  input   1      1 = auto-reload on expiry, 0 = one-shot
- count     output  16     current counter value (registered)
- busy      output  1      high while in RUN
- expire    output  1      one-cycle pulse on expiry (registered)

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low. All other state updates happen on the rising edge of `clk`.
- Reset values: count=0, reload=0, state=IDLE, busy=0, expire=0.
- Reset asserted mid-count aborts immediately. No expire pulse is generated.
- Internal reload register: written only by `load`.
- States:
  - IDLE: stopped; count held.
  - RUN: decrementing.
  - DONE: one-shot expired; count=0.
- `busy` = (state==RUN), decoded from the registered state.
- Priority per edge: reset > load > stop > start > count step.
- load (any state): count<=load_val, reload<=load_val, state<=IDLE, expire<=0.
- stop in RUN: state<=IDLE, count held (pause). Elsewhere stop has no effect. If stop and start are both high, stop wins.
- start in IDLE:
  - count!=0: state<=RUN. Counting begins the next edge.
  - count==0: ignored.
- start in DONE: count<=reload, state<=RUN. Reload is always nonzero here.
- start in RUN: ignored.
- RUN step, count>1: count<=count-1. `expire` stays 0.
- RUN step, count==1 (expiry edge):
  - `periodic` is sampled at this edge.
  - periodic=1: count<=reload, stay in RUN. Period is exactly `reload` cycles per expire.
  - periodic=0: count<=0, state<=DONE.
  - In both cases expire<=1 for exactly one cycle.
- `expire` is cleared on every edge that is not an expiry edge.
- Latency: after start is sampled with count=N, expire is high in the clock cycle following the N-th edge in RUN.
- Decrement is computed as count + 16'hFFFF (mod 2^16). Wrap below zero is unreachable, since RUN never steps from 0.
- load during the expiry edge: load wins; no expire pulse.

Test Plan:
- Reset: hold rst_n=0 asynchronously mid-RUN -> count=0, busy=0, expire=0 immediately, without a clock edge.
- One-shot: load 5, start, periodic=0 -> count 5,4,3,2,1,0 on successive edges; expire high exactly once when count=0; busy falls to 0; state DONE. A second start reloads 5 and repeats.
- Periodic: load 3, periodic=1, start, run 10 edges -> count 3,2,1,3,2,1,3,...; expire pulses every 3 cycles; busy stays 1.
- Pause/resume: load 0x0100, start, stop after 16 edges -> count holds 0x00F0. Start again -> resumes at 0x00EF next edge. stop+start together in RUN -> pauses.
- Zero/edge values:
  - load 0 then start -> stays IDLE, no expire.
  - load 16'hFFFF, start -> first step gives 16'hFFFE.
  - load 1, start -> expire after one RUN edge.
- Collision: load 7 asserted on the expiry edge of a running count -> count=7, IDLE, expire=0.
